ladybird_uart_mmio: RTL and testbench

// - Memory-mapped UART controller: slave on the core data bus, master of the serial interface byte ports.
// - Buffers TX and RX bytes in FIFOs and exposes DATA and STATUS registers.
// - Replaces the ad-hoc single-byte latch between data bus and serial interface; sits between ladybird_core and ladybird_serial_interface.

---
 rtl/ladybird_config_pkg.sv | 45 ++++
 rtl/ladybird_fifo.sv | 60 ++++++
 rtl/ladybird_uart_mmio.sv | 198 +++++++++++++++++++
 tb/tb_ladybird_uart_mmio.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybird_config_pkg.sv
// Shared Ladybird configuration: data width, UART register map and FSM states.
// Used by the UART MMIO controller and its FIFOs.
package ladybird_config;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        UART_DATA,
        UART_STATUS,
        UART_CTRL
    } uart_reg_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RX,
        WAIT_TX,
        RESP
    } uart_state_e;

    typedef struct packed {
        logic      hit;
        uart_reg_e rsel;
    } uart_dec_t;

    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_TX_SPACE = 1;
    localparam int STAT_OVERRUN  = 2;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    function automatic logic [XLEN-1:0] uart_status_word(
        input logic ovr,
        input logic tx_full,
        input logic rx_empty
    );
        logic [XLEN-1:0] w;
        w                = '0;
        w[STAT_RX_AVAIL] = ~rx_empty;
        w[STAT_TX_SPACE] = ~tx_full;
        w[STAT_OVERRUN]  = ovr;
        return w;
    endfunction

endpackage

// File: rtl/ladybird_fifo.sv
// Synchronous FIFO, power-of-two depth, async active-low reset.
// Push and pop may coincide at any occupancy; a pop on empty is ignored.
module ladybird_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             anrst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rptr_q];

    // A pop frees the slot a simultaneous push needs when full.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/ladybird_uart_mmio.sv
// Memory-mapped UART controller: DATA/STATUS registers over TX/RX FIFOs.
// Define LADYBIRD_UART_IRQ_EN to add the CTRL register and irq output.
module ladybird_uart_mmio
    import ladybird_config::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'hFFFF_FFF8,
    parameter int              FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              anrst,
    input  logic              bus_req,
    output logic              bus_gnt,
    input  logic [XLEN-1:0]   bus_addr,
    input  logic [XLEN/8-1:0] bus_wstrb,
    input  logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN-1:0]   bus_rdata,
    output logic              bus_rvalid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
`ifdef LADYBIRD_UART_IRQ_EN
    ,
    output logic              irq
`endif
);

    uart_state_e     state_q;
    logic [XLEN-1:0] addr_q;
    logic            is_wr_q;
    logic            strb0_q;
    logic [7:0]      wdata_q;
    logic            ovr_q;
    logic            ovr_d;

    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       tx_push, rx_push, rx_pop;
    logic       stat_rd, stat_clr;
    logic       rd_live, resp;
    uart_dec_t  in_dec, cur;
    logic       unused_wdata;

    function automatic uart_dec_t decode(input logic [XLEN-1:0] a);
        uart_dec_t d;
        d.hit  = 1'b1;
        d.rsel = UART_DATA;
        if (a == BASE_ADDR) begin
            d.rsel = UART_DATA;
        end else if (a == BASE_ADDR + XLEN'(4)) begin
            d.rsel = UART_STATUS;
`ifdef LADYBIRD_UART_IRQ_EN
        end else if (a == BASE_ADDR + XLEN'(8)) begin
            d.rsel = UART_CTRL;
`endif
        end else begin
            d.hit = 1'b0;
        end
        return d;
    endfunction

    assign unused_wdata = ^bus_wdata[XLEN-1:8];

    assign in_dec  = decode(bus_addr);
    assign cur     = decode(addr_q);
    assign rd_live = ~|bus_wstrb;
    assign resp    = (state_q == RESP);

    assign bus_gnt    = (state_q == IDLE);
    assign bus_rvalid = resp;

    // Side effects happen only on the single RESP cycle of a transfer.
    assign tx_push  = resp & is_wr_q & strb0_q & cur.hit
                    & (cur.rsel == UART_DATA);
    assign rx_pop   = resp & ~is_wr_q & cur.hit
                    & (cur.rsel == UART_DATA);
    assign stat_rd  = resp & ~is_wr_q & cur.hit
                    & (cur.rsel == UART_STATUS);
    assign stat_clr = stat_rd
                    | (resp & is_wr_q & cur.hit
                       & (cur.rsel == UART_STATUS)
                       & wdata_q[STAT_OVERRUN]);

    assign rx_push  = rx_valid & ~rx_full;
    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_head;

    ladybird_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .anrst   (anrst),
        .push_i  (tx_push),
        .din_i   (wdata_q),
        .pop_i   (tx_valid & tx_ready),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    ladybird_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .anrst   (anrst),
        .push_i  (rx_push),
        .din_i   (rx_data),
        .pop_i   (rx_pop),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

`ifdef LADYBIRD_UART_IRQ_EN
    logic [1:0] ctrl_q;
    logic       ctrl_rd;
    logic       irq_q;

    assign ctrl_rd = resp & ~is_wr_q & cur.hit & (cur.rsel == UART_CTRL);
    assign irq     = irq_q;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (resp & is_wr_q & strb0_q & cur.hit
                & (cur.rsel == UART_CTRL)) begin
                ctrl_q <= wdata_q[1:0];
            end
            irq_q <= (ctrl_q[CTRL_RX_IE] & ~rx_empty)
                   | (ctrl_q[CTRL_TX_IE] & tx_empty)
                   | ovr_q;
        end
    end
`endif

    always_comb begin
        bus_rdata = '0;
        unique case (1'b1)
            rx_pop:  bus_rdata = {{(XLEN-8){1'b0}}, rx_head};
            stat_rd: bus_rdata = uart_status_word(ovr_q, tx_full, rx_empty);
`ifdef LADYBIRD_UART_IRQ_EN
            ctrl_rd: bus_rdata = {{(XLEN-2){1'b0}}, ctrl_q};
`endif
            default: bus_rdata = '0;
        endcase
    end

    // A byte dropped in the same cycle as the clearing access keeps overrun set.
    always_comb begin
        ovr_d = ovr_q;
        if (stat_clr)             ovr_d = 1'b0;
        if (rx_valid & rx_full)   ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            strb0_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus_req) begin
                        addr_q  <= bus_addr;
                        is_wr_q <= ~rd_live;
                        strb0_q <= bus_wstrb[0];
                        wdata_q <= bus_wdata[7:0];
                        state_q <= RESP;
                        if (in_dec.hit && in_dec.rsel == UART_DATA) begin
                            if (rd_live && rx_empty) begin
                                state_q <= WAIT_RX;
                            end else if (!rd_live && bus_wstrb[0]
                                         && tx_full) begin
                                state_q <= WAIT_TX;
                            end
                        end
                    end
                end
                WAIT_RX: if (!rx_empty) state_q <= RESP;
                WAIT_TX: if (!tx_full)  state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ladybird_uart_mmio.sv
// Directed, scoreboard-checked bench for ladybird_uart_mmio.
// Bus responses and TX bytes are matched against expectation queues.
module tb_ladybird_uart_mmio;
    import ladybird_config::*;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam logic [31:0] STAT = 32'hFFFF_FFFC;

    logic        clk;
    logic        anrst;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
`ifdef LADYBIRD_UART_IRQ_EN
    logic        irq;
`endif

    ladybird_uart_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .anrst      (anrst),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
`ifdef LADYBIRD_UART_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] tx_exp[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic bus_op(input string tag, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input logic chk, input logic [31:0] exp,
                          output int lat);
        sb_t e;
        int  n;
        e.chk  = chk;
        e.data = exp;
        sb_q.push_back(e);
        @(negedge clk);
        bus_req   = 1'b1;
        bus_addr  = a;
        bus_wstrb = s;
        bus_wdata = d;
        n = 0;
        while (!bus_gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus_req   = 1'b0;
        bus_wstrb = '0;
        lat = 1;
        while (!bus_rvalid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " rvalid"}, 32'(bus_rvalid), 32'd1);
        e = sb_q.pop_front();
        if (bus_rvalid) begin
            if (e.chk) check({tag, " rdata"}, bus_rdata, e.data);
            @(negedge clk);
            check({tag, " pulse"}, 32'(bus_rvalid), 32'd0);
        end
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        #1;
        if (anrst && tx_valid && tx_ready) begin
            if (tx_exp.size() > 0) begin
                check("tx_data", 32'(tx_data), 32'(tx_exp.pop_front()));
            end else begin
                checks++;
                errors++;
                $error("FAIL tx_extra: got %h want none", tx_data);
            end
        end
    end

    initial begin
        int lat;
        int n;
        anrst     = 1'b0;
        bus_req   = 1'b0;
        bus_addr  = '0;
        bus_wstrb = '0;
        bus_wdata = '0;
        tx_ready  = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst gnt", 32'(bus_gnt), 32'd1);
        check("rst rvalid", 32'(bus_rvalid), 32'd0);
        check("rst rdata", bus_rdata, 32'd0);
        check("rst tx_valid", 32'(tx_valid), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst rx_ready", 32'(rx_ready), 32'd1);
        anrst = 1'b1;

        // single TX byte with the serial side ready
        tx_ready = 1'b1;
        tx_exp.push_back(8'h41);
        bus_op("wr41", BASE, 4'h1, 32'h41, 1'b0, 32'h0, lat);
        check("wr41 lat", 32'(lat), 32'd1);
        n = 0;
        while (!tx_valid && n < 2) begin
            @(negedge clk);
            n++;
        end
        check("wr41 tx_valid", 32'(tx_valid), 32'd1);
        repeat (2) @(negedge clk);
        check("wr41 drained", 32'(tx_exp.size()), 32'd0);

        // DATA read stalls until a byte arrives
        fork
            bus_op("rdwait", BASE, 4'h0, 32'h0, 1'b1, 32'h5A, lat);
            begin
                repeat (10) @(negedge clk);
                check("rdwait gnt", 32'(bus_gnt), 32'd0);
                check("rdwait rvalid", 32'(bus_rvalid), 32'd0);
                rx_send(8'h5A);
            end
        join
        check("rdwait lat", 32'(lat >= 10), 32'd1);
        bus_op("stat idle", STAT, 4'h0, 32'h0, 1'b1, 32'h2, lat);

        // RX overflow: 17th byte dropped, overrun sticky until read
        for (int i = 0; i < 17; i++) rx_send(8'h10 + 8'(i));
        check("rx full ready", 32'(rx_ready), 32'd0);
        bus_op("stat ovr", STAT, 4'h0, 32'h0, 1'b1, 32'h7, lat);
        check("stat ovr lat", 32'(lat), 32'd1);
        bus_op("stat clr", STAT, 4'h0, 32'h0, 1'b1, 32'h3, lat);
        for (int i = 0; i < 16; i++) begin
            bus_op("rx drain", BASE, 4'h0, 32'h0, 1'b1,
                   32'h10 + 32'(i), lat);
            check("rx drain lat", 32'(lat), 32'd1);
        end
        bus_op("stat empty", STAT, 4'h0, 32'h0, 1'b1, 32'h2, lat);

        // STATUS write: bit2 clears overrun, other bits do nothing
        for (int i = 0; i < 17; i++) rx_send(8'h20 + 8'(i));
        bus_op("wstat nop", STAT, 4'h1, 32'h3, 1'b0, 32'h0, lat);
        bus_op("stat ovr2", STAT, 4'h0, 32'h0, 1'b1, 32'h7, lat);
        rx_send(8'hEE);
        bus_op("wstat clr", STAT, 4'h1, 32'h4, 1'b0, 32'h0, lat);
        bus_op("stat ovr3", STAT, 4'h0, 32'h0, 1'b1, 32'h3, lat);
        for (int i = 0; i < 16; i++) begin
            bus_op("rx drain2", BASE, 4'h0, 32'h0, 1'b1,
                   32'h20 + 32'(i), lat);
        end

        // unmapped accesses and a DATA write without byte 0
        bus_op("unmap rd", 32'h0000_1000, 4'h0, 32'h0, 1'b1, 32'h0, lat);
        check("unmap rd lat", 32'(lat), 32'd1);
        bus_op("unmap wr", 32'h0000_1000, 4'hF, 32'hFF, 1'b0, 32'h0, lat);
        check("unmap wr lat", 32'(lat), 32'd1);
        bus_op("wr nostrb", BASE, 4'h2, 32'h77, 1'b0, 32'h0, lat);
        repeat (3) @(negedge clk);
        check("nostrb tx_valid", 32'(tx_valid), 32'd0);
`ifdef LADYBIRD_UART_IRQ_EN
        bus_op("ctrl wr", BASE + 32'd8, 4'h1, 32'h1, 1'b0, 32'h0, lat);
        bus_op("ctrl rd", BASE + 32'd8, 4'h0, 32'h0, 1'b1, 32'h1, lat);
        check("irq idle", 32'(irq), 32'd0);
        rx_send(8'h66);
        @(negedge clk);
        check("irq set", 32'(irq), 32'd1);
        bus_op("irq rd", BASE, 4'h0, 32'h0, 1'b1, 32'h66, lat);
        @(negedge clk);
        check("irq clr", 32'(irq), 32'd0);
        bus_op("ctrl off", BASE + 32'd8, 4'h1, 32'h0, 1'b0, 32'h0, lat);
`else
        bus_op("ctrl unmap", BASE + 32'd8, 4'h0, 32'h0, 1'b1, 32'h0, lat);
`endif
        bus_op("stat end", STAT, 4'h0, 32'h0, 1'b1, 32'h2, lat);

        // TX backpressure: 16 fit, the 17th waits for space
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx_exp.push_back(8'h80 + 8'(i));
            bus_op("tx fill", BASE, 4'h1, 32'h80 + 32'(i), 1'b0, 32'h0, lat);
            check("tx fill lat", 32'(lat), 32'd1);
        end
        bus_op("stat txfull", STAT, 4'h0, 32'h0, 1'b1, 32'h0, lat);
        tx_exp.push_back(8'h90);
        fork
            bus_op("tx stall", BASE, 4'h1, 32'h90, 1'b0, 32'h0, lat);
            begin
                repeat (5) @(negedge clk);
                check("tx stall gnt", 32'(bus_gnt), 32'd0);
                tx_ready = 1'b1;
                @(negedge clk);
                tx_ready = 1'b0;
            end
        join
        check("tx stall lat", 32'(lat > 1), 32'd1);
        check("tx popped", 32'(tx_exp.size()), 32'd16);

        // reset while a write is parked in WAIT_TX
        @(negedge clk);
        bus_req   = 1'b1;
        bus_addr  = BASE;
        bus_wstrb = 4'h1;
        bus_wdata = 32'h99;
        @(posedge clk);
        @(negedge clk);
        bus_req   = 1'b0;
        bus_wstrb = '0;
        check("waittx gnt", 32'(bus_gnt), 32'd0);
        repeat (3) @(negedge clk);
        anrst = 1'b0;
        #1;
        tx_exp.delete();
        check("mid rst gnt", 32'(bus_gnt), 32'd1);
        check("mid rst rvalid", 32'(bus_rvalid), 32'd0);
        check("mid rst rdata", bus_rdata, 32'd0);
        check("mid rst tx_valid", 32'(tx_valid), 32'd0);
        check("mid rst tx_data", 32'(tx_data), 32'd0);
        check("mid rst rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        anrst = 1'b1;
        bus_op("stat post", STAT, 4'h0, 32'h0, 1'b1, 32'h2, lat);
        check("post tx_valid", 32'(tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
